icmp_echo_engine: RTL and testbench

//  Single-clock ICMP responder between the IP receive demux and the Ethernet TX arbiter.

---
 rtl/icmp_echo_engine.sv | 234 +++++++++++++++++++++++
 tb/tb_icmp_echo_engine.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icmp_echo_engine.sv
// ICMP responder: buffers echo requests, replies with a folded checksum, flags
// destination-unreachable packets, and rate-limits replies per time window.
module icmp_echo_engine #(
  parameter int DEPTH_LOG2  = 11,
  parameter int RATE_WINDOW = 1250000,
  parameter int RATE_MAX    = 8
) (
  input  logic        rx_clock,
  input  logic        reset,
  input  logic        rx_enable,
  input  logic [7:0]  rx_data,
  input  logic [47:0] remote_mac,
  input  logic [31:0] remote_ip,
  input  logic        tx_enable,
  output logic        tx_request,
  output logic        tx_active,
  output logic [7:0]  tx_data,
  output logic [15:0] length,
  output logic [47:0] destination_mac,
  output logic [31:0] destination_ip,
  output logic        dst_unreachable,
  output logic [7:0]  unreach_code,
  output logic [15:0] reply_count,
  output logic [15:0] drop_count
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] HEADER  = 3'd1;
  localparam logic [2:0] PAYLOAD = 3'd2;
  localparam logic [2:0] FOLD    = 3'd3;
  localparam logic [2:0] TXREQ   = 3'd4;
  localparam logic [2:0] TX      = 3'd5;
  localparam logic [2:0] DROP    = 3'd6;

  localparam int BUF_BYTES = 1 << DEPTH_LOG2;
  localparam int CNT_W     = DEPTH_LOG2 + 1;
  localparam int WIN_W     = (RATE_WINDOW > 1) ? $clog2(RATE_WINDOW) : 1;

  logic [2:0]            state;
  logic                  is_unreach;
  logic [1:0]            hdr_idx;
  logic [CNT_W-1:0]      store_cnt;
  logic                  fold_phase;
  logic [15:0]           tx_idx;
  logic                  rx_prev;
  logic [31:0]           sum;
  logic [16:0]           fold_p1;
  logic [15:0]           csum;
  logic [7:0]            mem [0:BUF_BYTES-1];
  logic [WIN_W-1:0]      win_cnt;
  logic [15:0]           win_replies;

  logic                  start;
  logic                  full;
  logic                  buf_write;
  logic                  limit_hit;
  logic                  busy_drop;
  logic                  ovf_drop;
  logic                  rate_drop;
  logic                  reply_done;
  logic                  win_wrap;
  logic [31:0]           addend;
  logic [DEPTH_LOG2-1:0] rd_addr;
  logic [7:0]            next_byte;

  // First end-around fold: 32-bit sum into 17 bits.
  function automatic logic [16:0] fold_step(input logic [31:0] s);
    return {1'b0, s[15:0]} + {1'b0, s[31:16]};
  endfunction

  // Second fold absorbs the remaining carry, then one's complement.
  function automatic logic [15:0] fold_final(input logic [16:0] f);
    logic [15:0] f2;
    f2 = f[15:0] + {15'd0, f[16]};
    return ~f2;
  endfunction

  // Without a reset, a reset released mid-packet does not look like a new start.
  always_ff @(posedge rx_clock) begin
    rx_prev <= rx_enable;
  end

  always_comb begin
    start      = rx_enable && !rx_prev;
    full       = (store_cnt == CNT_W'(BUF_BYTES));
    buf_write  = (state == PAYLOAD) && rx_enable && !full;
    limit_hit  = (RATE_MAX != 0) && ({16'd0, win_replies} >= 32'(RATE_MAX));
    busy_drop  = start && (rx_data == 8'd8) &&
                 ((state == FOLD) || (state == TXREQ) || (state == TX));
    ovf_drop   = (state == PAYLOAD) && rx_enable && full;
    rate_drop  = (state == FOLD) && fold_phase && limit_hit;
    reply_done = (state == TX) && (tx_idx == length);
    win_wrap   = (win_cnt == WIN_W'(RATE_WINDOW - 1));
    addend     = store_cnt[0] ? {24'd0, rx_data} : {16'd0, rx_data, 8'd0};
    rd_addr    = DEPTH_LOG2'(tx_idx - 16'd4);
    case (tx_idx)
      16'd0, 16'd1: next_byte = 8'h00;
      16'd2:        next_byte = csum[15:8];
      16'd3:        next_byte = csum[7:0];
      default:      next_byte = mem[rd_addr];
    endcase
  end

  // Stage p0: payload capture and running sum; p1/p2: checksum folds.
  always_ff @(posedge rx_clock) begin
    if ((state == IDLE) && start)
      sum <= 32'd0;
    else if (buf_write)
      sum <= sum + addend;
    if (buf_write)
      mem[store_cnt[DEPTH_LOG2-1:0]] <= rx_data;
    if ((state == FOLD) && !fold_phase)
      fold_p1 <= fold_step(sum);
    if ((state == FOLD) && fold_phase)
      csum <= fold_final(fold_p1);
  end

  // A wrap and a reply on the same cycle leave the window count at one.
  always_ff @(posedge rx_clock) begin
    if (reset) begin
      win_cnt     <= '0;
      win_replies <= 16'd0;
    end else begin
      win_cnt <= win_wrap ? '0 : win_cnt + WIN_W'(1);
      if (reply_done)
        win_replies <= win_wrap ? 16'd1 :
                       (win_replies == 16'hFFFF) ? win_replies : win_replies + 16'd1;
      else if (win_wrap)
        win_replies <= 16'd0;
    end
  end

  always_ff @(posedge rx_clock) begin
    if (reset) begin
      state           <= IDLE;
      is_unreach      <= 1'b0;
      hdr_idx         <= 2'd0;
      store_cnt       <= '0;
      fold_phase      <= 1'b0;
      tx_idx          <= 16'd0;
      tx_request      <= 1'b0;
      tx_active       <= 1'b0;
      tx_data         <= 8'd0;
      length          <= 16'd0;
      destination_mac <= 48'd0;
      destination_ip  <= 32'd0;
      dst_unreachable <= 1'b0;
      unreach_code    <= 8'd0;
      reply_count     <= 16'd0;
      drop_count      <= 16'd0;
    end else begin
      dst_unreachable <= 1'b0;
      drop_count      <= drop_count + 16'(busy_drop) + 16'(ovf_drop) + 16'(rate_drop);
      case (state)
        IDLE: begin
          if (start) begin
            destination_mac <= remote_mac;
            destination_ip  <= remote_ip;
            store_cnt       <= '0;
            hdr_idx         <= 2'd1;
            is_unreach      <= (rx_data == 8'd3);
            if ((rx_data == 8'd8) || (rx_data == 8'd3))
              state <= HEADER;
            else
              state <= DROP;
          end
        end
        HEADER: begin
          if (!rx_enable) begin
            state <= IDLE;
          end else begin
            hdr_idx <= hdr_idx + 2'd1;
            if ((hdr_idx == 2'd1) && is_unreach) begin
              unreach_code    <= rx_data;
              dst_unreachable <= 1'b1;
              state           <= DROP;
            end else if ((hdr_idx == 2'd1) && (rx_data != 8'd0)) begin
              state <= DROP;
            end else if (hdr_idx == 2'd3) begin
              state <= PAYLOAD;
            end
          end
        end
        PAYLOAD: begin
          if (!rx_enable) begin
            state      <= FOLD;
            fold_phase <= 1'b0;
          end else if (full) begin
            state <= DROP;
          end else begin
            store_cnt <= store_cnt + CNT_W'(1);
          end
        end
        FOLD: begin
          if (!fold_phase) begin
            fold_phase <= 1'b1;
          end else if (limit_hit) begin
            state <= IDLE;
          end else begin
            length     <= 16'd4 + 16'(store_cnt);
            tx_request <= 1'b1;
            state      <= TXREQ;
          end
        end
        TXREQ: begin
          if (tx_enable) begin
            tx_request <= 1'b0;
            tx_active  <= 1'b1;
            tx_data    <= 8'h00;
            tx_idx     <= 16'd1;
            state      <= TX;
          end
        end
        TX: begin
          if (tx_idx == length) begin
            tx_active   <= 1'b0;
            tx_data     <= 8'h00;
            reply_count <= reply_count + 16'd1;
            state       <= IDLE;
          end else begin
            tx_data <= next_byte;
            tx_idx  <= tx_idx + 16'd1;
          end
        end
        DROP: begin
          if (!rx_enable)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_icmp_echo_engine.sv
// Scoreboard bench for icmp_echo_engine: directed spec cases plus randomized
// packet mixes checked against a packet-level reference model.
module tb_icmp_echo_engine;

  localparam int DEPTH_LOG2  = 10;
  localparam int RATE_WINDOW = 3000;
  localparam int RATE_MAX    = 2;
  localparam int BUF         = 1 << DEPTH_LOG2;

  logic        rx_clock;
  logic        reset;
  logic        rx_enable;
  logic [7:0]  rx_data;
  logic [47:0] remote_mac;
  logic [31:0] remote_ip;
  logic        tx_enable;
  logic        tx_request;
  logic        tx_active;
  logic [7:0]  tx_data;
  logic [15:0] length;
  logic [47:0] destination_mac;
  logic [31:0] destination_ip;
  logic        dst_unreachable;
  logic [7:0]  unreach_code;
  logic [15:0] reply_count;
  logic [15:0] drop_count;

  icmp_echo_engine #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .RATE_WINDOW(RATE_WINDOW),
    .RATE_MAX   (RATE_MAX)
  ) dut (
    .rx_clock       (rx_clock),
    .reset          (reset),
    .rx_enable      (rx_enable),
    .rx_data        (rx_data),
    .remote_mac     (remote_mac),
    .remote_ip      (remote_ip),
    .tx_enable      (tx_enable),
    .tx_request     (tx_request),
    .tx_active      (tx_active),
    .tx_data        (tx_data),
    .length         (length),
    .destination_mac(destination_mac),
    .destination_ip (destination_ip),
    .dst_unreachable(dst_unreachable),
    .unreach_code   (unreach_code),
    .reply_count    (reply_count),
    .drop_count     (drop_count)
  );

  initial rx_clock = 1'b0;
  always #5 rx_clock = ~rx_clock;

  int cyc;
  always @(posedge rx_clock) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Scoreboard queues filled by stimulus, drained by the monitor.
  int           exp_len[$];
  logic [47:0]  exp_mac[$];
  logic [31:0]  exp_ip[$];
  byte unsigned exp_bytes[$];
  logic [7:0]   exp_code[$];

  // Reference model state.
  int m_reply = 0;
  int m_drop  = 0;
  int win_replies = 0;

  byte unsigned payload[$];
  byte unsigned pkt[$];
  logic [47:0]  cur_mac;
  logic [31:0]  cur_ip;

  function automatic logic [15:0] ref_checksum();
    longint s = 0;
    for (int i = 0; i < payload.size(); i++)
      s += (i % 2 == 0) ? longint'(payload[i]) * 256 : longint'(payload[i]);
    while (s > 65535) s = (s & 65535) + (s >> 16);
    return ~(16'(s));
  endfunction

  task automatic push_expected(input logic [15:0] cs);
    exp_len.push_back(payload.size() + 4);
    exp_mac.push_back(cur_mac);
    exp_ip.push_back(cur_ip);
    exp_bytes.push_back(8'h00);
    exp_bytes.push_back(8'h00);
    exp_bytes.push_back(cs[15:8]);
    exp_bytes.push_back(cs[7:0]);
    foreach (payload[i]) exp_bytes.push_back(payload[i]);
  endtask

  // Monitor: collects each reply burst and compares it with the scoreboard.
  initial begin : monitor
    bit           in_reply;
    bit           aborted;
    byte unsigned got[$];
    int           n, bad;
    logic [47:0]  m;
    logic [31:0]  ip;
    byte unsigned b;
    in_reply = 0;
    aborted  = 0;
    forever begin
      @(negedge rx_clock);
      if (dst_unreachable) begin
        if (exp_code.size() == 0) chk("unreach_pulse_unexpected", 1, 0);
        else chk("unreach_code", unreach_code, exp_code.pop_front());
      end
      if (tx_active) begin
        if (!in_reply) begin
          in_reply = 1;
          aborted  = 0;
          got.delete();
        end
        if (reset) aborted = 1;
        got.push_back(tx_data);
      end else if (in_reply) begin
        in_reply = 0;
        if (exp_len.size() == 0) begin
          chk("reply_unexpected_bytes", got.size(), 0);
        end else begin
          n  = exp_len.pop_front();
          m  = exp_mac.pop_front();
          ip = exp_ip.pop_front();
          bad = 0;
          for (int i = 0; i < n; i++) begin
            b = exp_bytes.pop_front();
            if (!aborted && i < got.size() && got[i] != b) begin
              if (bad == 0) $display("reply byte %0d: got %02h expected %02h", i, got[i], b);
              bad++;
            end
          end
          if (!aborted) begin
            chk("reply_active_cycles", got.size(), n);
            chk("reply_length_port", length, n);
            chk("reply_dest_mac", destination_mac, m);
            chk("reply_dest_ip", destination_ip, ip);
            chk("reply_byte_mismatches", bad, 0);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge rx_clock);
    #1;
  endtask

  task automatic new_addr();
    cur_mac = {16'($urandom), 32'($urandom)};
    cur_ip  = 32'($urandom);
  endtask

  task automatic drive_pkt();
    remote_mac = cur_mac;
    remote_ip  = cur_ip;
    for (int i = 0; i < pkt.size(); i++) begin
      rx_enable = 1'b1;
      rx_data   = pkt[i];
      tick();
    end
    rx_enable = 1'b0;
    rx_data   = 8'h00;
    tick();
  endtask

  task automatic align();
    while ((cyc % RATE_WINDOW) != 5) tick();
    win_replies = 0;
  endtask

  task automatic check_counts(input string tag);
    chk({tag, "_reply_count"}, reply_count, m_reply & 16'hFFFF);
    chk({tag, "_drop_count"}, drop_count, m_drop & 16'hFFFF);
    chk({tag, "_request_idle"}, tx_request, 0);
  endtask

  // Echo request built from `payload`; lit_csum >= 0 supplies a literal checksum.
  task automatic echo_req(input bit inject, input int lit_csum);
    logic [15:0] cs;
    bit          reply;
    int          n;
    byte unsigned itype;
    new_addr();
    pkt.delete();
    pkt.push_back(8'h08);
    pkt.push_back(8'h00);
    pkt.push_back(8'($urandom));
    pkt.push_back(8'($urandom));
    foreach (payload[i]) pkt.push_back(payload[i]);
    reply = 0;
    if (payload.size() > BUF) m_drop++;
    else if (win_replies >= RATE_MAX) m_drop++;
    else begin
      reply = 1;
      cs = (lit_csum >= 0) ? 16'(lit_csum) : ref_checksum();
      push_expected(cs);
    end
    drive_pkt();
    if (!reply) begin
      repeat (6) tick();
      chk("no_request_when_dropped", tx_request, 0);
      return;
    end
    n = 0;
    while (!tx_request && n < 20) begin
      tick();
      n++;
    end
    if (!tx_request) begin
      chk("request_timeout", tx_request, 1);
      return;
    end
    if (inject) begin
      itype = ($urandom_range(0, 1) == 0) ? 8'h08 : 8'h03;
      new_addr();
      pkt.delete();
      pkt.push_back(itype);
      repeat (4) pkt.push_back(8'h00);
      drive_pkt();
      if (itype == 8'h08) m_drop++;
    end
    chk("request_held", tx_request, 1);
    repeat ($urandom_range(0, 3)) tick();
    tx_enable = 1'b1;
    tick();
    tx_enable = 1'b0;
    chk("request_drops_at_grant", tx_request, 0);
    chk("active_after_grant", tx_active, 1);
    n = 0;
    while (tx_active && n < payload.size() + 10) begin
      tick();
      n++;
    end
    chk("tx_finished", tx_active, 0);
    m_reply++;
    win_replies++;
  endtask

  task automatic unreach_req(input logic [7:0] code);
    new_addr();
    pkt.delete();
    pkt.push_back(8'h03);
    pkt.push_back(code);
    pkt.push_back(8'($urandom));
    pkt.push_back(8'($urandom));
    repeat ($urandom_range(0, 3)) pkt.push_back(8'($urandom));
    exp_code.push_back(code);
    drive_pkt();
    repeat (3) tick();
  endtask

  task automatic other_req();
    byte unsigned t;
    t = 8'($urandom);
    if (t == 8'h08 || t == 8'h03) t = 8'h00;
    new_addr();
    pkt.delete();
    pkt.push_back(t);
    repeat ($urandom_range(0, 7)) pkt.push_back(8'($urandom));
    drive_pkt();
    repeat (3) tick();
  endtask

  task automatic short_echo();
    new_addr();
    pkt.delete();
    pkt.push_back(8'h08);
    repeat ($urandom_range(0, 2)) pkt.push_back(8'h00);
    drive_pkt();
    repeat (6) tick();
    chk("short_no_request", tx_request, 0);
  endtask

  initial begin : stimulus
    int n;
    reset      = 1'b1;
    rx_enable  = 1'b0;
    rx_data    = 8'h00;
    remote_mac = 48'd0;
    remote_ip  = 32'd0;
    tx_enable  = 1'b0;
    repeat (5) tick();
    chk("rst_tx_request", tx_request, 0);
    chk("rst_tx_active", tx_active, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_length", length, 0);
    chk("rst_dest_mac", destination_mac, 0);
    chk("rst_dest_ip", destination_ip, 0);
    chk("rst_unreach", dst_unreachable, 0);
    chk("rst_unreach_code", unreach_code, 0);
    chk("rst_reply_count", reply_count, 0);
    chk("rst_drop_count", drop_count, 0);
    reset = 1'b0;
    tick();

    // Directed cases from the datasheet examples.
    align();
    payload = '{8'h00, 8'h01, 8'h00, 8'h02};
    echo_req(0, 'hFFFC);
    payload = '{8'hAB};
    echo_req(0, 'h54FF);
    check_counts("directed");

    align();
    payload.delete();
    repeat (600) payload.push_back(8'hFF);
    echo_req(0, 'h0000);
    unreach_req(8'h03);
    check_counts("ff600_unreach");

    // Buffer exactly full replies; one byte beyond is dropped.
    align();
    payload.delete();
    repeat (BUF) payload.push_back(8'($urandom));
    echo_req(0, -1);
    check_counts("buffer_full");
    align();
    payload.delete();
    repeat (BUF + 16) payload.push_back(8'($urandom));
    echo_req(0, -1);
    check_counts("buffer_overflow");

    // Three requests in one window with RATE_MAX=2.
    align();
    for (int k = 0; k < 3; k++) begin
      payload = '{8'h10, 8'h20, 8'h30};
      echo_req(0, -1);
    end
    check_counts("rate_limit");

    for (int ph = 0; ph < 8; ph++) begin
      align();
      for (int k = 0; k < 3; k++) begin
        n = $urandom_range(0, 9);
        if (n <= 5) begin
          payload.delete();
          repeat ($urandom_range(0, 40)) payload.push_back(8'($urandom));
          echo_req($urandom_range(0, 3) == 0, -1);
        end else if (n <= 7) begin
          unreach_req(8'($urandom));
        end else if (n == 8) begin
          other_req();
        end else begin
          short_echo();
        end
      end
      check_counts("random");
    end

    // Reset in the middle of a reply aborts it and clears every counter.
    align();
    payload = '{8'h11, 8'h22, 8'h33, 8'h44};
    new_addr();
    pkt = '{8'h08, 8'h00, 8'h00, 8'h00};
    foreach (payload[i]) pkt.push_back(payload[i]);
    push_expected(ref_checksum());
    drive_pkt();
    n = 0;
    while (!tx_request && n < 20) begin
      tick();
      n++;
    end
    chk("mid_tx_request_seen", tx_request, 1);
    tx_enable = 1'b1;
    tick();
    tx_enable = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    chk("mid_tx_reset_active", tx_active, 0);
    chk("mid_tx_reset_request", tx_request, 0);
    chk("mid_tx_reset_data", tx_data, 0);
    chk("mid_tx_reset_replies", reply_count, 0);
    chk("mid_tx_reset_drops", drop_count, 0);
    reset = 1'b0;
    m_reply = 0;
    m_drop = 0;
    win_replies = 0;
    tick();
    payload = '{8'h00, 8'h01, 8'h00, 8'h02};
    echo_req(0, 'hFFFC);
    check_counts("after_reset");

    repeat (5) tick();
    chk("scoreboard_replies_left", exp_len.size(), 0);
    chk("scoreboard_unreach_left", exp_code.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
